vision_test_ctrl: RTL and testbench
===================================

// Module: vision_test_ctrl
// PURPOSE
//  Sequences one E-chart vision test. Steps the level 4.0..5.3 and picks a random E direction per trial.
//  Judges debounced key responses and holds the final result.
//  Drives vision_bcd/ctr_signal of the 2-digit+symbol display scanner and dir/trial_start of the symbol drawer.
// PARAMETERS
//  N_TRIALS     4           trials per level (2..15)
//  PASS_CNT     3           correct answers needed to pass a level (1..N_TRIALS)
//  TIMEOUT_CYC  250000000   clk cycles allowed per trial before it counts as wrong (>=2)
//  LFSR_SEED    8'hA5       reset value of direction LFSR (nonzero)
// PORTS
//  clk          in   1  system clock
//  rst_n        in   1  ASYNCHRONOUS, ACTIVE-HIGH reset (1 = reset)
//  start        in   1  1-cycle pulse: begin/restart test
//  resp_valid   in   1  1-cycle pulse: user answered
//  resp_dir     in   2  answered direction (0 up,1 right,2 down,3 left), valid with resp_valid
//  vision_bcd   out  8  [7:4] integer digit, [3:0] tenths digit, BCD; 8'hFF = blank
//  ctr_signal   out  1  1 while test in progress (display shows "-")
//  dir          out  2  E direction of current trial
//  trial_start  out  1  1-cycle pulse when a new trial's dir becomes valid
//  done         out  1  1 while result is held
//  below_range  out  1  1 with done when level 4.0 was failed
// BEHAVIOUR
//  Reset values: state IDLE, vision_bcd 8'h40, ctr_signal 0, dir = LFSR_SEED[1:0], trial_start 0,
//   done 0, below_range 0, all counters 0. All outputs registered.
//  LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, shifts every clk incl. IDLE. Never all-zero.
//  FSM IDLE -> SHOW -> JUDGE -> (SHOW | DONE); DONE -> SHOW on start.
//  start (any state, incl. mid-trial):
//   - next cycle: SHOW, level 4.0, trial=0, correct=0, wrong=0, timer=0
//   - outputs: ctr_signal=1, done=0, below_range=0, dir=lfsr[1:0], trial_start=1.
//  SHOW:
//   - timer counts up each cycle. resp_valid -> JUDGE, hit = (resp_dir==dir).
//   - timer==TIMEOUT_CYC-1 without resp -> JUDGE, hit=0.
//   - resp_valid on the timeout cycle counts as a response.
//  JUDGE (1 cycle): update correct/wrong, trial+1, then:
//   - wrong > N_TRIALS-PASS_CNT -> level FAILED (early; remaining trials skipped).
//   - correct == PASS_CNT after the last trial -> level PASSED.
//   - else next trial: SHOW, timer=0, new dir, trial_start pulse.
//  PASSED:
//   - level 5.3 -> DONE with result 5.3.
//   - otherwise BCD-increment level (x.9 -> (x+1).0), clear trial/correct/wrong, start next trial.
//  FAILED:
//   - level 4.0 -> DONE, vision_bcd=8'hFF, below_range=1.
//   - otherwise DONE, vision_bcd = level - 0.1 (BCD-decrement, 5.0 -> 4.9).
//  During SHOW/JUDGE vision_bcd = current level. vision_bcd, dir and ctr_signal change only on state updates.
//  DONE: ctr_signal=0, done=1; outputs held until start or reset. resp_valid ignored outside SHOW.
//  trial_start is high exactly the cycle dir first holds the new value.
//  Reset asserted mid-test returns everything to reset values immediately (async).
//  Valid levels: 4.0..5.3 (14); vision_bcd never holds non-BCD except 8'hFF.
// TESTING
//  1 reset, start, answer resp_dir=dir on every trial -> levels 40,41..49,50..53 in order; done=1, vision_bcd=8'h53, ctr_signal=0.
//  2 pass 4.0..4.7, then answer wrong twice at 4.8 -> FAILED after 2nd wrong (early); vision_bcd=8'h47, done=1.
//  3 wrong twice at 4.0 -> vision_bcd=8'hFF, below_range=1, done=1; then start -> below_range=0, vision_bcd=8'h40.
//  4 TIMEOUT_CYC=16, no responses -> each trial ends after 16 cycles as wrong; done 2 trials later with below_range=1.
//  5 start asserted mid-trial at level 4.6 -> next cycle level 8'h40, trial_start=1, counters 0.
//  6 rst_n pulsed mid-SHOW and resp_valid on the timeout cycle (hit) -> async reset values; the timeout-cycle response is judged a correct answer.

Source files
------------

// File: rtl/vision_test_ctrl.sv
// E-chart vision test sequencer.
// Steps the acuity level from 4.0 to 5.3 and draws a random E direction for
// each trial. Each trial ends on a key response or a timeout. The final result
// is held for the display scanner until the next start.
//
//   state | meaning
//   IDLE  | after reset, waiting for the first start
//   SHOW  | symbol on screen, timer running, waiting for a response
//   JUDGE | score the trial, then pick next trial / next level / result
//   DONE  | result held on vision_bcd, done=1
//
// rst_n is active-high, despite its name.
module vision_test_ctrl #(
  parameter int          N_TRIALS    = 4,
  parameter int          PASS_CNT    = 3,
  parameter int          TIMEOUT_CYC = 250000000,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       resp_valid,
  input  logic [1:0] resp_dir,
  output logic [7:0] vision_bcd,
  output logic       ctr_signal,
  output logic [1:0] dir,
  output logic       trial_start,
  output logic       done,
  output logic       below_range
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHOW  = 2'd1;
  localparam logic [1:0] S_JUDGE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [7:0] LVL_MIN = 8'h40;
  localparam logic [7:0] LVL_MAX = 8'h53;
  localparam logic [7:0] BLANK   = 8'hFF;

  logic [1:0]    state_q, state_d;
  logic [7:0]    level_q, level_d;
  logic [3:0]    trial_q, trial_d;
  logic [3:0]    correct_q, correct_d;
  logic [3:0]    wrong_q, wrong_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          hit_q, hit_d;
  logic [7:0]    lfsr_q, lfsr_d;
  logic [7:0]    vision_q, vision_d;
  logic          ctr_q, ctr_d;
  logic [1:0]    dir_q, dir_d;
  logic          ts_q, ts_d;
  logic          done_q, done_d;
  logic          below_q, below_d;

  logic [3:0]    trial_n, correct_n, wrong_n;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    return (v[3:0] == 4'd0) ? {v[7:4] - 4'd1, 4'd9} : {v[7:4], v[3:0] - 4'd1};
  endfunction

  assign trial_n   = trial_q + 4'd1;
  assign correct_n = correct_q + {3'd0, hit_q};
  assign wrong_n   = wrong_q + {3'd0, ~hit_q};

  // Next-state logic: start overrides everything, otherwise step the FSM
  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    trial_d   = trial_q;
    correct_d = correct_q;
    wrong_d   = wrong_q;
    timer_d   = timer_q;
    hit_d     = hit_q;
    vision_d  = vision_q;
    ctr_d     = ctr_q;
    dir_d     = dir_q;
    ts_d      = 1'b0;
    done_d    = done_q;
    below_d   = below_q;
    lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    if (start) begin
      state_d   = S_SHOW;
      level_d   = LVL_MIN;
      vision_d  = LVL_MIN;
      trial_d   = 4'd0;
      correct_d = 4'd0;
      wrong_d   = 4'd0;
      timer_d   = '0;
      hit_d     = 1'b0;
      ctr_d     = 1'b1;
      done_d    = 1'b0;
      below_d   = 1'b0;
      dir_d     = lfsr_q[1:0];
      ts_d      = 1'b1;
    end else begin
      case (state_q)
        S_SHOW: begin
          timer_d = timer_q + TW'(1);
          if (resp_valid) begin
            state_d = S_JUDGE;
            hit_d   = (resp_dir == dir_q);
          end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
            state_d = S_JUDGE;
            hit_d   = 1'b0;
          end
        end
        S_JUDGE: begin
          trial_d   = trial_n;
          correct_d = correct_n;
          wrong_d   = wrong_n;
          if (wrong_n > 4'(N_TRIALS - PASS_CNT)) begin
            // Failing is decided as soon as passing becomes impossible.
            state_d = S_DONE;
            ctr_d   = 1'b0;
            done_d  = 1'b1;
            if (level_q == LVL_MIN) begin
              vision_d = BLANK;
              below_d  = 1'b1;
            end else begin
              vision_d = bcd_dec(level_q);
            end
          end else if (trial_n == 4'(N_TRIALS) && level_q == LVL_MAX) begin
            state_d  = S_DONE;
            ctr_d    = 1'b0;
            done_d   = 1'b1;
            vision_d = LVL_MAX;
          end else begin
            if (trial_n == 4'(N_TRIALS)) begin
              level_d   = bcd_inc(level_q);
              vision_d  = bcd_inc(level_q);
              trial_d   = 4'd0;
              correct_d = 4'd0;
              wrong_d   = 4'd0;
            end
            state_d = S_SHOW;
            timer_d = '0;
            dir_d   = lfsr_q[1:0];
            ts_d    = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q   <= S_IDLE;
      level_q   <= LVL_MIN;
      trial_q   <= 4'd0;
      correct_q <= 4'd0;
      wrong_q   <= 4'd0;
      timer_q   <= '0;
      hit_q     <= 1'b0;
      lfsr_q    <= LFSR_SEED;
      vision_q  <= LVL_MIN;
      ctr_q     <= 1'b0;
      dir_q     <= LFSR_SEED[1:0];
      ts_q      <= 1'b0;
      done_q    <= 1'b0;
      below_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      trial_q   <= trial_d;
      correct_q <= correct_d;
      wrong_q   <= wrong_d;
      timer_q   <= timer_d;
      hit_q     <= hit_d;
      lfsr_q    <= lfsr_d;
      vision_q  <= vision_d;
      ctr_q     <= ctr_d;
      dir_q     <= dir_d;
      ts_q      <= ts_d;
      done_q    <= done_d;
      below_q   <= below_d;
    end
  end

  assign vision_bcd  = vision_q;
  assign ctr_signal  = ctr_q;
  assign dir         = dir_q;
  assign trial_start = ts_q;
  assign done        = done_q;
  assign below_range = below_q;

endmodule

// File: tb/tb_vision_test_ctrl.sv
// Bench for vision_test_ctrl: randomized answers scored by a level/trial model.
module tb_vision_test_ctrl;

  localparam int         N    = 4;
  localparam int         P    = 3;
  localparam int         T    = 16;
  localparam logic [7:0] SEED = 8'hA5;

  localparam int POL_RAND = 0, POL_ALL = 1, POL_FAIL48 = 2, POL_WRONG = 3,
                 POL_NONE = 4, POL_EDGE = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       resp_valid = 1'b0;
  logic [1:0] resp_dir = 2'd0;
  logic [7:0] vision_bcd;
  logic       ctr_signal;
  logic [1:0] dir;
  logic       trial_start;
  logic       done;
  logic       below_range;

  int n_checks = 0;
  int n_errors = 0;

  vision_test_ctrl #(
    .N_TRIALS(N), .PASS_CNT(P), .TIMEOUT_CYC(T), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .resp_valid(resp_valid),
    .resp_dir(resp_dir), .vision_bcd(vision_bcd), .ctr_signal(ctr_signal),
    .dir(dir), .trial_start(trial_start), .done(done), .below_range(below_range)
  );

  always #5 clk = ~clk;

  // Reference direction generator: x^8+x^6+x^5+x^4+1, one shift per clock.
  // m_prev is the sequence value that was current just before the last edge.
  logic [7:0] m_lfsr, m_prev;
  always @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      m_lfsr <= SEED;
      m_prev <= SEED;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Level index 0..13 maps to 4.0..5.3.
  function automatic logic [7:0] bcd_of(input int idx);
    int v;
    v = 40 + idx;
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic check_trial_begin(input string tag, input int idx);
    check_val({tag, "_ts"},    32'(trial_start), 32'd1);
    check_val({tag, "_lvl"},   32'(vision_bcd),  32'(bcd_of(idx)));
    check_val({tag, "_ctr"},   32'(ctr_signal),  32'd1);
    check_val({tag, "_done"},  32'(done),        32'd0);
    check_val({tag, "_below"}, 32'(below_range), 32'd0);
    check_val({tag, "_dir"},   32'(dir),         32'(m_prev[1:0]));
  endtask

  task automatic check_done(input logic [7:0] exp_v, input logic exp_below);
    check_val("done_flag",  32'(done),        32'd1);
    check_val("done_bcd",   32'(vision_bcd),  32'(exp_v));
    check_val("done_below", 32'(below_range), 32'(exp_below));
    check_val("done_ctr",   32'(ctr_signal),  32'd0);
    check_val("done_ts",    32'(trial_start), 32'd0);
    // Responses while the result is held must not disturb it.
    for (int k = 0; k < 2; k++) begin
      resp_valid = 1'b1;
      resp_dir   = 2'($urandom_range(0, 3));
      @(negedge clk);
      resp_valid = 1'b0;
      @(negedge clk);
    end
    check_val("hold_bcd",  32'(vision_bcd), 32'(exp_v));
    check_val("hold_done", 32'(done),       32'd1);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_outcome(output int lat);
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (trial_start || done) break;
    end
    if (lat >= 40) check_val("outcome_wait", 32'd0, 32'd1);
  endtask

  // Runs one complete test under an answering policy; abort_level >= 0 restarts
  // the test once, mid-trial, when that level is reached.
  task automatic run_test(input int policy, input int abort_level);
    int   lvl, tr, wr, kind, d, lat, guard, r;
    bit   fin, aborted;
    lvl = 0; tr = 0; wr = 0; fin = 0; aborted = 0; guard = 0;
    do_start();
    check_trial_begin("start", 0);
    while (!fin && guard < 200) begin
      guard++;
      if (abort_level >= 0 && !aborted && lvl == abort_level && tr == 1) begin
        aborted = 1;
        repeat (3) @(negedge clk);
        do_start();
        check_trial_begin("restart", 0);
        lvl = 0; tr = 0; wr = 0;
        continue;
      end
      d = $urandom_range(0, T - 1);
      case (policy)
        POL_RAND: begin
          r = $urandom_range(0, 99);
          kind = (r < 80) ? 0 : (r < 92) ? 1 : 2;
        end
        POL_ALL:    kind = 0;
        POL_FAIL48: kind = (lvl < 8) ? 0 : 1;
        POL_WRONG:  kind = 1;
        POL_NONE:   kind = 2;
        default: begin
          kind = 0;
          d = T - 1;
        end
      endcase
      if (kind == 2) begin
        wait_outcome(lat);
        check_val("lat_timeout", 32'(lat), 32'(T + 1));
      end else begin
        for (int k = 0; k < d; k++) begin
          @(negedge clk);
          if (k == 0) check_val("ts_pulse", 32'(trial_start), 32'd0);
        end
        resp_valid = 1'b1;
        resp_dir   = (kind == 0) ? dir : dir + 2'($urandom_range(1, 3));
        @(negedge clk);
        resp_valid = 1'b0;
        wait_outcome(lat);
        check_val("lat_resp", 32'(lat), 32'd1);
      end
      tr++;
      if (kind != 0) wr++;
      if (wr > N - P) begin
        check_done((lvl == 0) ? 8'hFF : bcd_of(lvl - 1), lvl == 0);
        fin = 1;
      end else if (tr == N) begin
        if (lvl == 13) begin
          check_done(8'h53, 1'b0);
          fin = 1;
        end else begin
          lvl++;
          tr = 0; wr = 0;
          check_trial_begin("next_level", lvl);
        end
      end else begin
        check_trial_begin("next_trial", lvl);
      end
    end
    if (!fin) check_val("test_end", 32'd0, 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_bcd"},   32'(vision_bcd),  32'h40);
    check_val({tag, "_ctr"},   32'(ctr_signal),  32'd0);
    check_val({tag, "_dir"},   32'(dir),         32'(SEED[1:0]));
    check_val({tag, "_ts"},    32'(trial_start), 32'd0);
    check_val({tag, "_done"},  32'(done),        32'd0);
    check_val({tag, "_below"}, 32'(below_range), 32'd0);
  endtask

  initial begin
    #2 rst_n = 1'b1;
    #1 check_reset_vals("rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    // IDLE ignores responses.
    resp_valid = 1'b1;
    @(negedge clk);
    resp_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("idle");

    run_test(POL_ALL, -1);
    run_test(POL_FAIL48, -1);
    run_test(POL_WRONG, -1);
    run_test(POL_NONE, -1);
    run_test(POL_ALL, 6);

    // Asynchronous reset in the middle of a trial.
    do_start();
    check_trial_begin("pre_rst", 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    #1 check_reset_vals("mid_rst");
    @(negedge clk);
    rst_n = 1'b0;
    run_test(POL_EDGE, -1);

    for (int i = 0; i < 6; i++) run_test(POL_RAND, -1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got 0 exp 1");
    $fatal(1);
  end

endmodule
